capture_mem_reader: RTL and testbench



---
 rtl/capture_mem_reader.sv | 189 ++++++++++++++++++
 tb/tb_capture_mem_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_mem_reader.sv
// capture_mem_reader: readback engine for the banked capture SRAM array.
// It takes a start bank/address and word count, issues one single-port read
// per cycle across consecutive banks, absorbs the 1-cycle SRAM read latency,
// and streams the words out on a valid/ready interface.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   start, abort           request pulse (sampled in IDLE) / cancel transfer
//   start_bank/addr,rd_len transfer descriptor
//   rd_chip_en, rd_addr    one-hot bank read enable and shared read address
//   mem_dout               concatenated bank Q outputs, bank k at [k*DATA_W +: DATA_W]
//   m_valid/m_ready/m_data/m_last  output stream
//   busy, done, err        status: not idle / normal completion pulse / rejected start pulse
module capture_mem_reader #(
   parameter int NUM_BANK = 24,
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 36,
   parameter int LEN_W    = 20
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [4:0]                 start_bank,
   input  logic [ADDR_W-1:0]          start_addr,
   input  logic [LEN_W-1:0]           rd_len,
   output logic [NUM_BANK-1:0]        rd_chip_en,
   output logic [ADDR_W-1:0]          rd_addr,
   input  logic [NUM_BANK*DATA_W-1:0] mem_dout,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_W-1:0]          m_data,
   output logic                       m_last,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam logic [4:0] LAST_BANK = 5'(NUM_BANK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state;
   state_t              state_nxt;

   // read pointer / remaining-word count of the active transfer
   logic [4:0]          bank;
   logic [ADDR_W-1:0]   addr;
   logic [LEN_W-1:0]    remaining;
   logic                primed;

   // read issued last cycle: its data is on mem_dout this cycle
   logic                inflight;
   logic [4:0]          inf_bank;
   logic                inf_last;

   // 2-entry output FIFO
   logic [DATA_W-1:0]   fifo_data [2];
   logic                fifo_last [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          fifo_count;

   logic                err_q;
   logic                start_ok;
   logic                start_bad;
   logic                pop;
   logic                issue;
   logic [2:0]          occupancy;
   logic [DATA_W-1:0]   rd_word;

   always_comb begin
      start_ok  = 1'b0;
      start_bad = 1'b0;
      if (state == IDLE && start && !abort) begin
         if (start_bank > LAST_BANK) start_bad = 1'b1;
         else                        start_ok  = 1'b1;
      end
   end

   assign m_valid = (fifo_count != 2'd0);
   assign m_data  = fifo_data[rd_ptr];
   assign m_last  = fifo_last[rd_ptr];
   assign pop     = m_valid & m_ready;
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign err     = err_q;

   // Words already owed to the FIFO: its contents plus the read in flight,
   // less the word leaving this cycle. A new read lands two edges later, so
   // only this cycle's pop can be counted on to free a slot.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

   // First RUN cycle is a setup cycle (primed=0), so the first word appears
   // on m_valid three edges after the start edge.
   assign issue = (state == RUN) && primed && !abort &&
                  (remaining != '0) && (occupancy < 3'd2);

   always_comb begin
      rd_chip_en = '0;
      rd_addr    = '0;
      if (issue) begin
         rd_chip_en[bank] = 1'b1;
         rd_addr          = addr;
      end
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned k = 0; k < NUM_BANK; k++) begin
         if (inf_bank == 5'(k)) rd_word = mem_dout[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = (rd_len == '0) ? DONE : RUN;
         RUN:     if (issue && remaining == LEN_W'(1)) state_nxt = DRAIN;
         DRAIN:   if (fifo_count == 2'd0 && !inflight) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank         <= '0;
         addr         <= '0;
         remaining    <= '0;
         primed       <= 1'b0;
         inflight     <= 1'b0;
         inf_bank     <= '0;
         inf_last     <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_count   <= 2'd0;
         err_q        <= 1'b0;
      end else begin
         err_q <= start_bad;
         if (abort) begin
            // drop the word in flight and everything buffered
            primed     <= 1'b0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
         end else begin
            if (start_ok) begin
               bank      <= start_bank;
               addr      <= start_addr;
               remaining <= rd_len;
               primed    <= 1'b0;
            end else if (state == RUN) begin
               primed <= 1'b1;
            end

            if (issue) begin
               addr      <= addr + ADDR_W'(1);
               remaining <= remaining - LEN_W'(1);
               if (addr == '1) bank <= (bank == LAST_BANK) ? 5'd0 : bank + 5'd1;
            end

            inflight <= issue;
            inf_bank <= bank;
            inf_last <= (remaining == LEN_W'(1));

            if (inflight) begin
               fifo_data[wr_ptr] <= rd_word;
               fifo_last[wr_ptr] <= inf_last;
               wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
         end
      end
   end

endmodule

// File: tb/tb_capture_mem_reader.sv
module tb_capture_mem_reader;
   localparam int NUM_BANK = 24;
   localparam int ADDR_W   = 15;
   localparam int DATA_W   = 36;
   localparam int LEN_W    = 20;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       start;
   logic                       abort;
   logic [4:0]                 start_bank;
   logic [ADDR_W-1:0]          start_addr;
   logic [LEN_W-1:0]           rd_len;
   logic [NUM_BANK-1:0]        rd_chip_en;
   logic [ADDR_W-1:0]          rd_addr;
   logic [NUM_BANK*DATA_W-1:0] mem_dout;
   logic                       m_valid;
   logic                       m_ready;
   logic [DATA_W-1:0]          m_data;
   logic                       m_last;
   logic                       busy;
   logic                       done;
   logic                       err;

   always #5 clk = ~clk;

   capture_mem_reader #(
      .NUM_BANK (NUM_BANK),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .LEN_W    (LEN_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .start_bank (start_bank),
      .start_addr (start_addr),
      .rd_len     (rd_len),
      .rd_chip_en (rd_chip_en),
      .rd_addr    (rd_addr),
      .mem_dout   (mem_dout),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // memory contents: bank 2 holds addr+0x100, other banks carry a bank tag
   function automatic logic [DATA_W-1:0] mem_word(input int b, input int a);
      return (DATA_W'(b ^ 2) << 28) | DATA_W'(a + 'h100);
   endfunction

   // SRAM model: Q registered on a chip-enabled edge, held otherwise
   logic [DATA_W-1:0] q [NUM_BANK];
   always @(posedge clk) begin
      for (int k = 0; k < NUM_BANK; k++)
         if (rd_chip_en[k]) q[k] <= mem_word(k, int'(rd_addr));
   end
   always_comb begin
      mem_dout = '0;
      for (int k = 0; k < NUM_BANK; k++) mem_dout[k*DATA_W +: DATA_W] = q[k];
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int                iss_bank[$];
   int                iss_addr[$];
   int                iss_cyc[$];
   int                acc_cyc[$];
   logic [DATA_W-1:0] got_data[$];
   bit                got_last[$];
   int n_done, n_err, busy_cnt, max_out, onehot_bad, stable_bad, first_valid;
   bit                prev_stall = 1'b0;
   bit                prev_kill  = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_last;

   always @(negedge clk) begin
      if ($countones(rd_chip_en) > 1) onehot_bad++;
      for (int k = 0; k < NUM_BANK; k++) begin
         if (rd_chip_en[k]) begin
            iss_bank.push_back(k);
            iss_addr.push_back(int'(rd_addr));
            iss_cyc.push_back(cyc);
         end
      end
      if (m_valid && m_ready) begin
         got_data.push_back(m_data);
         got_last.push_back(m_last);
         acc_cyc.push_back(cyc);
      end
      if (iss_bank.size() - got_data.size() > max_out) max_out = iss_bank.size() - got_data.size();
      if (prev_stall && !prev_kill && (!m_valid || m_data !== prev_data || m_last !== prev_last))
         stable_bad++;
      if (done) n_done++;
      if (err) n_err++;
      if (busy) busy_cnt++;
      if (m_valid && first_valid < 0) first_valid = cyc;
      prev_stall = m_valid && !m_ready;
      prev_kill  = abort || rst;
      prev_data  = m_data;
      prev_last  = m_last;
   end

   task automatic clear_mon();
      iss_bank.delete(); iss_addr.delete(); iss_cyc.delete(); acc_cyc.delete();
      got_data.delete(); got_last.delete();
      n_done = 0; n_err = 0; busy_cnt = 0; max_out = 0;
      onehot_bad = 0; stable_bad = 0; first_valid = -1;
   endtask

   typedef struct {
      logic [4:0] bank;
      int         addr;
      int         len;
      int         ready_mode;   // 0 always ready, 1 stall window then random, 2 random
      int         restart_at;   // cycle of an extra start while busy, 0 = none
      bit         exp_err;
   } vec_t;

   vec_t vt [9];

   function automatic logic ready_for(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) begin
         if (c < 5)   return 1'b1;
         if (c <= 14) return 1'b0;
      end
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_and_check(input int idx, input vec_t v);
      int    exp_b[$];
      int    exp_a[$];
      int    b, a, n_exp, mism, lastbad, cyc_l, t0;
      string pfx;
      pfx = $sformatf("v%0d_", idx);
      clear_mon();
      b = v.bank;
      a = v.addr;
      n_exp = v.exp_err ? 0 : v.len;
      for (int i = 0; i < n_exp; i++) begin
         exp_b.push_back(b);
         exp_a.push_back(a);
         if (a == 32767) begin
            a = 0;
            b = (b == NUM_BANK - 1) ? 0 : b + 1;
         end else a++;
      end

      @(posedge clk); #1;
      start      = 1'b1;
      start_bank = v.bank;
      start_addr = ADDR_W'(v.addr);
      rd_len     = LEN_W'(v.len);
      m_ready    = ready_for(v.ready_mode, 0);
      t0         = cyc;
      cyc_l      = 0;
      while (cyc_l < 3000) begin
         @(posedge clk); #1;
         cyc_l++;
         if (v.restart_at == cyc_l) begin
            start = 1'b1; start_bank = 5'd9; start_addr = 15'd7; rd_len = 20'd3;
         end else start = 1'b0;
         m_ready = ready_for(v.ready_mode, cyc_l);
         if (cyc_l >= 2 && !busy) break;
      end
      start   = 1'b0;
      m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      check({pfx, "busy_end"}, busy, 0);
      check({pfx, "err_pulses"}, n_err, v.exp_err ? 1 : 0);
      check({pfx, "done_pulses"}, n_done, v.exp_err ? 0 : 1);
      check({pfx, "reads"}, iss_bank.size(), n_exp);
      mism = 0;
      for (int i = 0; i < iss_bank.size() && i < n_exp; i++)
         if (iss_bank[i] != exp_b[i] || iss_addr[i] != exp_a[i]) mism++;
      check({pfx, "read_seq_errs"}, mism, 0);
      check({pfx, "words"}, got_data.size(), n_exp);
      mism = 0;
      lastbad = 0;
      for (int i = 0; i < got_data.size() && i < n_exp; i++) begin
         if (got_data[i] !== mem_word(exp_b[i], exp_a[i])) mism++;
         if (got_last[i] != (i == n_exp - 1)) lastbad++;
      end
      check({pfx, "data_errs"}, mism, 0);
      check({pfx, "last_errs"}, lastbad, 0);
      check({pfx, "over_2_outstanding"}, (max_out > 2), 0);
      check({pfx, "unstable_stall"}, stable_bad, 0);
      check({pfx, "not_onehot"}, onehot_bad, 0);
      if (v.exp_err) check({pfx, "busy_cycles"}, busy_cnt, 0);
      if (n_exp > 0) check({pfx, "first_valid_edges"}, first_valid - t0 - 1, 3);
      if (n_exp > 0 && v.ready_mode == 0 && iss_cyc.size() == n_exp && acc_cyc.size() == n_exp) begin
         check({pfx, "read_span"}, iss_cyc[n_exp-1] - iss_cyc[0], n_exp - 1);
         check({pfx, "word_span"}, acc_cyc[n_exp-1] - acc_cyc[0], n_exp - 1);
      end
   endtask

   // start a 100-word transfer from bank 4 and wait for ten accepted words
   task automatic start_long(input string tag);
      int cyc_l;
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; start_bank = 5'd4; start_addr = '0; rd_len = 20'd100; m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc_l = 0;
      while (got_data.size() < 10 && cyc_l < 200) begin
         @(posedge clk); #1;
         cyc_l++;
      end
      check({tag, "_reached_10_words"}, got_data.size() >= 10, 1);
   endtask

   task automatic check_after_kill(input string tag);
      int n_iss, n_acc, mism;
      n_iss = iss_bank.size();
      n_acc = got_data.size();
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_done_pulses"}, n_done, 0);
      check({tag, "_reads_after"}, iss_bank.size() - n_iss, 0);
      check({tag, "_words_after"}, got_data.size() - n_acc, 0);
      mism = 0;
      for (int i = 0; i < got_data.size(); i++)
         if (got_data[i] !== mem_word(4, i)) mism++;
      check({tag, "_prefix_errs"}, mism, 0);
   endtask

   initial begin
      vt[0] = '{5'd2,  100,   4,  0, 0, 1'b0};  // basic
      vt[1] = '{5'd0,  32766, 4,  0, 0, 1'b0};  // bank crossing
      vt[2] = '{5'd23, 32767, 2,  0, 0, 1'b0};  // global wrap
      vt[3] = '{5'd5,  0,     16, 1, 0, 1'b0};  // backpressure
      vt[4] = '{5'd7,  1000,  0,  0, 0, 1'b0};  // zero length
      vt[5] = '{5'd24, 0,     5,  0, 0, 1'b1};  // bad bank
      vt[6] = '{5'd31, 5,     3,  0, 0, 1'b1};  // bad bank
      vt[7] = '{5'd11, 32760, 40, 2, 0, 1'b0};  // random ready across a bank edge
      vt[8] = '{5'd3,  50,    8,  0, 2, 1'b0};  // start while busy ignored

      rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
      start_bank = '0; start_addr = '0; rd_len = '0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", {rd_chip_en, rd_addr, m_valid, m_last, busy, done, err}, 0);
      check("reset_data", m_data, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_and_check(i, vt[i]);

      // abort mid-transfer
      start_long("abort");
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_chip_en", rd_chip_en, 0);
      check("abort_m_valid", m_valid, 0);
      check("abort_busy", busy, 0);
      check_after_kill("abort");

      // reset mid-transfer
      start_long("rst");
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ctl", {rd_chip_en, rd_addr, m_valid, m_last, busy, done, err}, 0);
      check("rst_mid_data", m_data, 0);
      rst = 1'b0;
      check_after_kill("rst");

      run_and_check(99, vt[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
